// File: rtl/ah4_tuner_responder_if.sv
// ============================================================================
// ah4_tuner_responder_if : ATU connector pins plus tuning-engine handshake
// Rev 1.0
// ============================================================================
`default_nettype none

interface ah4_tuner_responder_if;
  logic        atu_start;
  logic        atu_status;
  logic        tune_req;
  logic        tune_abort;
  logic        tune_done;
  logic        tune_fail;
  logic        tuned;
  logic        fault;
  logic [15:0] last_tune_ms;

  modport slave (
    input  atu_start, tune_done, tune_fail,
    output atu_status, tune_req, tune_abort, tuned, fault, last_tune_ms
  );

  modport master (
    output atu_start, tune_done, tune_fail,
    input  atu_status, tune_req, tune_abort, tuned, fault, last_tune_ms
  );
endinterface

`default_nettype wire

// File: rtl/ah4_tuner_responder.sv
// ============================================================================
// ah4_tuner_responder : tuner-side AH-4 START/KEY responder with ms timers
// Rev 1.0
// ============================================================================
`default_nettype none

module ah4_tuner_responder #(
  parameter int CLK_HZ          = 48000000,
  parameter int MIN_START_MS    = 50,
  parameter int MAX_START_MS    = 2000,
  parameter int ACK_DELAY_MS    = 20,
  parameter int TUNE_TIMEOUT_MS = 8000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  ah4_tuner_responder_if.slave        bus
);

  localparam logic [31:0] c_PRESC_MAX = 32'(CLK_HZ / 1000 - 1);
  localparam logic [15:0] c_MIN       = 16'(MIN_START_MS);
  localparam logic [15:0] c_MAX       = 16'(MAX_START_MS);
  localparam logic [15:0] c_ACK       = 16'(ACK_DELAY_MS);
  localparam logic [15:0] c_TIMEOUT   = 16'(TUNE_TIMEOUT_MS);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_MEASURE  = 3'd1,
    S_ACK_WAIT = 3'd2,
    S_BUSY     = 3'd3,
    S_STUCK    = 3'd4
  } state_t;

  state_t      r_state;
  logic [31:0] r_presc;
  logic        r_s1, r_s2, r_s3;
  logic [15:0] r_width;
  logic [15:0] r_timer;
  logic [15:0] r_busy;
  logic        r_status, r_req, r_abort, r_tuned, r_fault;
  logic [15:0] r_last;

  logic        w_tick, w_rise, w_fall;
  logic [15:0] w_busy_inc;

  assign w_tick     = (r_presc == 32'd0);
  assign w_rise     = r_s2 & ~r_s3;
  assign w_fall     = ~r_s2 & r_s3;
  assign w_busy_inc = (&r_busy) ? r_busy : r_busy + 16'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= c_PRESC_MAX;
    end else begin
      r_presc <= r_presc - 32'd1;
    end
  end

  // r_s2 is the synchronized START level; r_s3 only feeds the edge detect
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= bus.atu_start;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_width  <= '0;
      r_timer  <= '0;
      r_busy   <= '0;
      r_status <= 1'b0;
      r_req    <= 1'b0;
      r_abort  <= 1'b0;
      r_tuned  <= 1'b0;
      r_fault  <= 1'b0;
      r_last   <= '0;
    end else begin
      r_req   <= 1'b0;
      r_abort <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_rise) begin
            r_state <= S_MEASURE;
            r_width <= '0;
          end
        end
        S_MEASURE: begin
          if (w_fall) begin
            if (r_width >= c_MIN) begin
              r_state <= S_ACK_WAIT;
              r_timer <= c_ACK;
              r_tuned <= 1'b0;
              r_fault <= 1'b0;
            end else begin
              r_state <= S_IDLE;
            end
          end else if (w_tick && r_s2) begin
            r_width <= r_width + 16'd1;
            if (r_width + 16'd1 >= c_MAX) begin
              r_state <= S_STUCK;
              r_fault <= 1'b1;
              r_tuned <= 1'b0;
            end
          end
        end
        S_ACK_WAIT: begin
          if (w_rise) begin
            r_state <= S_MEASURE;
            r_width <= '0;
          end else if (w_tick) begin
            if (r_timer <= 16'd1) begin
              r_state  <= S_BUSY;
              r_status <= 1'b1;
              r_req    <= 1'b1;
              r_busy   <= '0;
            end else begin
              r_timer <= r_timer - 16'd1;
            end
          end
        end
        S_BUSY: begin
          // Done beats fail beats timeout beats a fresh START request
          if (bus.tune_done) begin
            r_state  <= S_IDLE;
            r_status <= 1'b0;
            r_tuned  <= 1'b1;
            r_last   <= r_busy;
          end else if (bus.tune_fail) begin
            r_state  <= S_IDLE;
            r_status <= 1'b0;
            r_fault  <= 1'b1;
            r_last   <= r_busy;
          end else if (w_tick && (w_busy_inc >= c_TIMEOUT)) begin
            r_state  <= S_IDLE;
            r_status <= 1'b0;
            r_abort  <= 1'b1;
            r_fault  <= 1'b1;
            r_busy   <= w_busy_inc;
            r_last   <= w_busy_inc;
          end else if (w_rise) begin
            r_state  <= S_MEASURE;
            r_status <= 1'b0;
            r_abort  <= 1'b1;
            r_width  <= '0;
          end else if (w_tick) begin
            r_busy <= w_busy_inc;
          end
        end
        S_STUCK: begin
          if (w_fall) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_status <= 1'b0;
        end
      endcase
    end
  end

  assign bus.atu_status   = r_status;
  assign bus.tune_req     = r_req;
  assign bus.tune_abort   = r_abort;
  assign bus.tuned        = r_tuned;
  assign bus.fault        = r_fault;
  assign bus.last_tune_ms = r_last;

endmodule

`default_nettype wire

// File: tb/tb_ah4_tuner_responder.sv
// ============================================================================
// tb_ah4_tuner_responder : directed bench, scaled to 4 clocks per ms tick
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_ah4_tuner_responder;

  localparam int CPM = 4;  // clocks per ms with CLK_HZ = 4000

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  int   req_cnt = 0;
  int   abort_cnt = 0;

  ah4_tuner_responder_if bus ();

  ah4_tuner_responder #(
    .CLK_HZ(4000), .MIN_START_MS(10), .MAX_START_MS(100),
    .ACK_DELAY_MS(5), .TUNE_TIMEOUT_MS(300)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.tune_req === 1'b1)   req_cnt++;
    if (bus.tune_abort === 1'b1) abort_cnt++;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input logic [31:0] obs, input int lo, input int hi);
    total++;
    assert (((obs >= 32'(lo)) && (obs <= 32'(hi))) === 1'b1) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic wait_status(input logic val, input int maxc, output int cyc);
    cyc = 0;
    while (bus.atu_status !== val && cyc < maxc) begin
      step(1);
      cyc++;
    end
    if (bus.atu_status !== val) cyc = -1;
  endtask

  task automatic start_pulse(input int ms);
    bus.atu_start = 1'b1;
    step(ms * CPM);
    bus.atu_start = 1'b0;
  endtask

  initial begin
    int cyc, r0, a0;
    rst_n = 1'b0;
    bus.atu_start = 1'b0;
    bus.tune_done = 1'b0;
    bus.tune_fail = 1'b0;
    step(3);
    chk("rst_status", bus.atu_status, 0);
    chk("rst_req", bus.tune_req, 0);
    chk("rst_abort", bus.tune_abort, 0);
    chk("rst_tuned", bus.tuned, 0);
    chk("rst_fault", bus.fault, 0);
    chk("rst_last", bus.last_tune_ms, 0);
    rst_n = 1'b1;
    step(2);

    // Normal tune: 50 ms START, 5 ms ack delay, done after 100 ms busy
    r0 = req_cnt;
    start_pulse(50);
    wait_status(1'b1, 60, cyc);
    chk_rng("t1_ack_delay", cyc, 20, 23);
    chk("t1_req_with_status", bus.tune_req, 1);
    step(400);
    bus.tune_done = 1'b1;
    step(1);
    bus.tune_done = 1'b0;
    chk("t1_status", bus.atu_status, 0);
    chk("t1_tuned", bus.tuned, 1);
    chk("t1_fault", bus.fault, 0);
    chk("t1_last", bus.last_tune_ms, 100);
    chk("t1_req_count", req_cnt - r0, 1);

    // Glitch below minimum width: nothing changes
    r0 = req_cnt;
    start_pulse(5);
    step(40);
    chk("t2_status", bus.atu_status, 0);
    chk("t2_req_count", req_cnt - r0, 0);
    chk("t2_tuned_kept", bus.tuned, 1);
    chk("t2_fault_kept", bus.fault, 0);
    chk("t2_last_kept", bus.last_tune_ms, 100);

    // Stuck START, then recovery with an engine failure
    r0 = req_cnt;
    bus.atu_start = 1'b1;
    step(105 * CPM);
    chk("t3_stuck_fault", bus.fault, 1);
    chk("t3_stuck_tuned", bus.tuned, 0);
    chk("t3_stuck_status", bus.atu_status, 0);
    step(20);
    bus.atu_start = 1'b0;
    step(20);
    chk("t3_stuck_req_count", req_cnt - r0, 0);
    chk("t3_fault_held", bus.fault, 1);
    start_pulse(50);
    wait_status(1'b1, 60, cyc);
    chk_rng("t3_ack_delay", cyc, 20, 23);
    chk("t3_fault_cleared", bus.fault, 0);
    step(160);
    bus.tune_fail = 1'b1;
    step(1);
    bus.tune_fail = 1'b0;
    chk("t3_fail_status", bus.atu_status, 0);
    chk("t3_fail_fault", bus.fault, 1);
    chk("t3_fail_tuned", bus.tuned, 0);
    chk("t3_fail_last", bus.last_tune_ms, 40);
    step(4);
    bus.tune_done = 1'b1;
    step(1);
    bus.tune_done = 1'b0;
    step(2);
    chk("t3_done_ignored_idle", bus.tuned, 0);

    // Silent engine: timeout exactly 300 ticks after status rises
    a0 = abort_cnt;
    start_pulse(50);
    wait_status(1'b1, 60, cyc);
    chk_rng("t4_ack_delay", cyc, 20, 23);
    wait_status(1'b0, 1300, cyc);
    chk("t4_timeout_cycles", cyc, 1200);
    chk("t4_abort_pulse", bus.tune_abort, 1);
    chk("t4_fault", bus.fault, 1);
    chk("t4_tuned", bus.tuned, 0);
    chk("t4_last", bus.last_tune_ms, 300);
    step(2);
    chk("t4_abort_count", abort_cnt - a0, 1);

    // Re-request during BUSY: immediate abort, fresh ack wait
    a0 = abort_cnt;
    r0 = req_cnt;
    start_pulse(50);
    wait_status(1'b1, 60, cyc);
    step(160);
    bus.atu_start = 1'b1;
    wait_status(1'b0, 10, cyc);
    chk("t5_abort_latency", cyc, 3);
    chk("t5_abort_pulse", bus.tune_abort, 1);
    step(50 * CPM);
    bus.atu_start = 1'b0;
    wait_status(1'b1, 60, cyc);
    chk_rng("t5_ack_delay", cyc, 20, 23);
    step(2);
    chk("t5_req_count", req_cnt - r0, 2);
    chk("t5_abort_count", abort_cnt - a0, 1);
    step(2);
    bus.tune_done = 1'b1;
    step(1);
    bus.tune_done = 1'b0;
    chk("t5_tuned", bus.tuned, 1);
    chk("t5_last", bus.last_tune_ms, 1);

    // Reset mid-BUSY: status drops, flags clear, no abort
    a0 = abort_cnt;
    start_pulse(50);
    wait_status(1'b1, 60, cyc);
    step(80);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    chk("t6_status", bus.atu_status, 0);
    chk("t6_tuned", bus.tuned, 0);
    chk("t6_fault", bus.fault, 0);
    chk("t6_last", bus.last_tune_ms, 0);
    step(2);
    chk("t6_no_abort", abort_cnt - a0, 0);

    // tune_done on the very cycle the timeout would fire
    a0 = abort_cnt;
    start_pulse(50);
    wait_status(1'b1, 60, cyc);
    chk_rng("t7_ack_delay", cyc, 20, 23);
    step(1199);
    bus.tune_done = 1'b1;
    step(1);
    bus.tune_done = 1'b0;
    chk("t7_status", bus.atu_status, 0);
    chk("t7_tuned", bus.tuned, 1);
    chk("t7_fault", bus.fault, 0);
    chk("t7_last", bus.last_tune_ms, 299);
    step(2);
    chk("t7_no_abort", abort_cnt - a0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ah4_tuner_responder.md
Name: ah4_tuner_responder

Overview:
- Tuner-side end of the AH-4 style START/KEY handshake.
- It qualifies the radio's START pulse by width, then raises the status (busy) line while an internal tuning engine runs. It drops the line on completion, failure or timeout.
- It sits between the external ATU connector pins and the local L/C tuning engine. It also serves as a bench model of the ATU for the radio-side controller.

Parameters:
- CLK_HZ, 48000000, system clock frequency; the 1 ms tick is derived from it.
- MIN_START_MS, 50, minimum START high width accepted as a tune request.
- MAX_START_MS, 2000, START high this long is treated as stuck and raises a fault.
- ACK_DELAY_MS, 20, delay from accepted START falling edge to status assertion.
- TUNE_TIMEOUT_MS, 8000, maximum busy time before the tune is forced to fail.
- All *_MS parameters are in the range 1..65535.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, synchronous active-low reset.
- atu_start, input, 1, START line from the radio, asynchronous, active high.
- atu_status, output, 1, KEY/busy line to the radio, high while tuning.
- tune_req, output, 1, one-cycle pulse that starts the tuning engine.
- tune_abort, output, 1, one-cycle pulse that aborts the tuning engine.
- tune_done, input, 1, engine success, sampled in BUSY only.
- tune_fail, input, 1, engine failure, sampled in BUSY only.
- tuned, output, 1, last tune succeeded.
- fault, output, 1, last request failed, timed out or START was stuck.
- last_tune_ms, output, 16, duration of the last completed BUSY period in ms.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - State=IDLE; prescaler=0; all timers=0.
  - atu_status, tune_req, tune_abort, tuned and fault = 0; last_tune_ms = 0.
  - Reset mid-operation drops atu_status on the next edge. No abort pulse is issued.
- Prescaler:
  - Counts down from CLK_HZ/1000-1.
  - tick=1 for one cycle when the count is 0, then it reloads.
  - The first tick after reset occurs on the cycle after reset is released.
- Input conditioning:
  - atu_start passes through a 2-flop synchronizer, giving start_s.
  - rise and fall are one-cycle edge detects on start_s.
  - Input-to-edge latency is 3 cycles.
- Timers: 16-bit; all timing is in ticks, with ±1 ms resolution.
- State machine (evaluated every clk; timers step on tick):
  - IDLE:
    - On rise: go to MEASURE, width=0.
  - MEASURE:
    - On tick with start_s=1: width+1.
    - If width reaches MAX_START_MS: go to STUCK, set fault=1, clear tuned.
    - On fall with width>=MIN_START_MS: go to ACK_WAIT, timer=ACK_DELAY_MS, clear tuned and fault.
    - On fall with width<MIN_START_MS: return to IDLE (glitch, no flag change).
  - ACK_WAIT:
    - On tick, decrement timer. At 0: go to BUSY, atu_status=1, tune_req=1 for one cycle, busy counter=0.
    - A rise here returns to MEASURE (request restarted). No tune_req is issued.
  - BUSY:
    - Busy counter increments on tick, saturating at 65535.
    - tune_done=1: go to IDLE, atu_status=0, tuned=1, last_tune_ms=counter.
    - tune_fail=1: go to IDLE, atu_status=0, fault=1, last_tune_ms=counter.
    - Busy counter reaches TUNE_TIMEOUT_MS: go to IDLE, atu_status=0, tune_abort pulse, fault=1, last_tune_ms=counter.
    - Rise on START: tune_abort pulse, atu_status=0, go to MEASURE, width=0 (radio re-requests).
    - Priority when simultaneous: tune_done > tune_fail > timeout > rise. Done and fail together count as done.
  - STUCK:
    - atu_status stays 0.
    - On fall: go to IDLE. fault stays 1 until the next accepted request.
  - Unused encodings return to IDLE.
- Outputs are registered. atu_status changes on the same edge as the state change.
- tune_done and tune_fail are ignored outside BUSY.

Test Plan:
- START high 500 ms:
  - After fall+20 ms, atu_status=1 and one tune_req pulse is issued.
  - tune_done at 3000 ms into BUSY: atu_status=0, tuned=1, fault=0, last_tune_ms=3000±1.
- START high 30 ms (below minimum):
  - No tune_req, atu_status stays 0, state returns to IDLE.
  - Flags are unchanged from the prior values.
- START held high 2000 ms:
  - fault=1, no tune_req.
  - After START drops, the next valid 500 ms pulse clears fault and tunes normally.
- Accepted request, engine silent:
  - atu_status falls at 8000 ms and one tune_abort pulse is issued.
  - fault=1, last_tune_ms=8000.
- New 500 ms START pulse during BUSY:
  - Immediate tune_abort pulse and atu_status=0.
  - A fresh ACK_WAIT follows, then tune_req 20 ms after the new fall.
- rst_n low for 1 cycle mid-BUSY:
  - Next edge: atu_status=0, tuned=0, fault=0, last_tune_ms=0, no tune_abort.
  - tune_done in the same cycle as the timeout: tuned=1, fault=0.
